// File: rtl/uart_tx_sched.sv
// Two-source front end for a single UART transmitter: a round-robin arbiter feeds a shared byte FIFO,
// and a sequencer launches each byte with a one-cycle DV pulse, waits out the frame and an idle gap.
module uart_tx_sched #(
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Req0_Valid,
  input  logic [7:0]                    i_Req0_Byte,
  output logic                          o_Req0_Ready,
  input  logic                          i_Req1_Valid,
  input  logic [7:0]                    i_Req1_Byte,
  output logic                          o_Req1_Ready,
  output logic                          o_Tx_DV,
  output logic [7:0]                    o_Tx_Byte,
  input  logic                          i_Tx_Active,
  input  logic                          i_Tx_Done,
  input  logic                          i_Err_Clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Busy,
  output logic                          o_Err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACT  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rr_last1;
  logic          grant0;
  logic          grant1;
  logic          full;
  logic          push;
  logic          pop;
  logic          err_set;
  logic [7:0]    push_byte;
  logic [1:0]    state;
  logic [TW-1:0] timer;

  // rr_last1 remembers whether req1 was the last source served; a tie goes to the other one.
  assign full         = (count == CW'(FIFO_DEPTH));
  assign grant0       = i_Req0_Valid & (~i_Req1_Valid | rr_last1);
  assign grant1       = i_Req1_Valid & (~i_Req0_Valid | ~rr_last1);
  assign o_Req0_Ready = grant0 & ~full;
  assign o_Req1_Ready = grant1 & ~full;
  assign push         = (grant0 | grant1) & ~full;
  assign push_byte    = grant1 ? i_Req1_Byte : i_Req0_Byte;

  // A launch also waits for Done to drop, so a frame left over from before our reset is respected.
  assign pop     = (state == S_IDLE) & (count != '0) & ~i_Tx_Active & ~i_Tx_Done;
  assign err_set = (state == S_WAIT_ACT) & ~i_Tx_Active & (timer == TW'(ACK_TIMEOUT - 1));

  assign o_Fifo_Count = count;
  assign o_Busy       = (state != S_IDLE) | (count != '0);

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_last1 <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rr_last1 <= grant1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
      o_Err     <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      if (err_set) begin
        o_Err <= 1'b1;
      end else if (i_Err_Clr) begin
        o_Err <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            o_Tx_Byte <= fifo_mem[rd_ptr];
            o_Tx_DV   <= 1'b1;
            timer     <= '0;
            state     <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT: begin
          if (i_Tx_Active) begin
            state <= S_WAIT_DONE;
          end else if (err_set) begin
            timer <= '0;
            state <= S_GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            timer <= '0;
            state <= S_GAP;
          end
        end
        default: begin
          if (timer == TW'(GAP_CYCLES - 1)) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a small transmitter model answers DV pulses, and
// per-requester drivers feed byte queues while logging accept and launch cycles.
module tb_uart_tx_sched;

  localparam int DEPTH    = 8;
  localparam int GAP      = 2;
  localparam int ACK      = 4;
  localparam int FRAME    = 4;
  localparam int M_NORMAL = 0;
  localparam int M_HOLD   = 1;
  localparam int M_SILENT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0v = 1'b0;
  logic [7:0] r0b = 8'h00;
  logic       r0r;
  logic       r1v = 1'b0;
  logic [7:0] r1b = 8'h00;
  logic       r1r;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] fifo_count;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = M_NORMAL;
  int busy_cnt = 0;
  int dv_double = 0;
  bit prev_dv = 1'b0;
  bit acc0 = 1'b0;
  bit acc1 = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] acc_log[$];
  logic [7:0] tx_log[$];
  int         acc_cyc[$];
  int         tx_cyc[$];
  int         done_log[$];

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req0_Valid(r0v), .i_Req0_Byte(r0b), .o_Req0_Ready(r0r),
    .i_Req1_Valid(r1v), .i_Req1_Byte(r1b), .o_Req1_Ready(r1r),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .i_Err_Clr(err_clr), .o_Fifo_Count(fifo_count), .o_Busy(busy), .o_Err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are judged mid-cycle, when the inputs have settled.
  always @(negedge clk) begin
    acc0 = r0v && r0r && rst_n;
    acc1 = r1v && r1r && rst_n;
    if (acc0) begin acc_log.push_back(r0b); acc_cyc.push_back(cyc); end
    if (acc1) begin acc_log.push_back(r1b); acc_cyc.push_back(cyc); end
  end

  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin r0v = 1'b1; r0b = q0[0]; end else begin r0v = 1'b0; r0b = 8'h00; end
    if (q1.size() > 0) begin r1v = 1'b1; r1b = q1[0]; end else begin r1v = 1'b0; r1b = 8'h00; end
  end

  // Transmitter model: Active for FRAME cycles after DV, then Done for one cycle with Active low.
  always @(posedge clk) begin
    #1;
    if (tx_dv) begin
      if (prev_dv) dv_double++;
      tx_log.push_back(tx_byte);
      tx_cyc.push_back(cyc);
    end
    prev_dv = tx_dv;
    tx_done = 1'b0;
    case (mode)
      M_HOLD:   tx_active = 1'b1;
      M_SILENT: begin tx_active = 1'b0; busy_cnt = 0; end
      default: begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin tx_active = 1'b0; tx_done = 1'b1; done_log.push_back(cyc); end
        end else if (tx_active) begin
          tx_active = 1'b0; tx_done = 1'b1; done_log.push_back(cyc);
        end
        if (tx_dv) begin tx_active = 1'b1; busy_cnt = FRAME; end
      end
    endcase
  end

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); tx_log.delete(); tx_cyc.delete(); done_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int budget;
    budget = 2000;
    while (tx_log.size() < n && budget > 0) begin @(negedge clk); budget--; end
    ok = (tx_log.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int budget;
    budget = 2000;
    while ((busy !== 1'b0 || tx_active !== 1'b0) && budget > 0) begin @(negedge clk); budget--; end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_dv !== 1'b0) begin errors++; $display("[TB] FAIL reset_dv: got %0h expected 0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %02h expected 00", tx_byte); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0h expected 0", err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({r0r, r1r, tx_dv, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_release: got %04b expected 0000", {r0r, r1r, tx_dv, busy}); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    mode = M_NORMAL;
    q0.push_back(8'hA5); q0.push_back(8'h5A);
    wait_tx(2, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_wait: got %0d frames expected 2", tx_log.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %0h expected 1", busy); end
    checks++; if (acc_log[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_accept: got %02h expected a5", acc_log[0]); end
    checks++; if (tx_log[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_byte: got %02h expected a5", tx_log[0]); end
    checks++; if (tx_cyc[0] - acc_cyc[0] !== 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", tx_cyc[0] - acc_cyc[0]); end
    checks++; if (tx_log[1] !== 8'h5A) begin errors++; $display("[TB] FAIL single_byte2: got %02h expected 5a", tx_log[1]); end
    checks++; if (tx_cyc[1] !== done_log[0] + GAP + 2) begin errors++; $display("[TB] FAIL single_gap: got %0d expected %0d", tx_cyc[1], done_log[0] + GAP + 2); end
    wait_idle(ok);
    checks++; if (!ok || fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL single_idle: got busy=%0h count=%0d expected 0", busy, fifo_count); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp_q[$];
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'h10 + 8'(i)); q1.push_back(8'h20 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i)); exp_q.push_back(8'h20 + 8'(i));
    end
    wait_tx(8, ok);
    wait_idle(ok);
    for (int i = 0; i < 8; i++) begin
      checks++; if (acc_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rr_accept[%0d]: got %02h expected %02h", i, acc_log[i], exp_q[i]); end
      checks++; if (tx_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rr_tx[%0d]: got %02h expected %02h", i, tx_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_full();
    bit ok;
    logic [7:0] exp_q[$];
    clear_logs();
    mode = M_HOLD;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) q0.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h30 + 8'(i));
    exp_q.push_back(8'h40); exp_q.push_back(8'h38);
    repeat (12) @(negedge clk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("[TB] FAIL full_count: got %0d expected 8", fifo_count); end
    checks++; if (r0r !== 1'b0) begin errors++; $display("[TB] FAIL full_ready0: got %0h expected 0", r0r); end
    q1.push_back(8'h40);
    repeat (2) @(negedge clk);
    checks++; if ({r0r, r1r} !== 2'b00) begin errors++; $display("[TB] FAIL full_ready_both: got %02b expected 00", {r0r, r1r}); end
    checks++; if (tx_log.size() !== 0) begin errors++; $display("[TB] FAIL full_no_launch: got %0d expected 0", tx_log.size()); end
    mode = M_NORMAL;
    wait_tx(10, ok);
    wait_idle(ok);
    checks++; if (tx_log.size() !== 10) begin errors++; $display("[TB] FAIL full_frames: got %0d expected 10", tx_log.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (acc_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL full_accept[%0d]: got %02h expected %02h", i, acc_log[i], exp_q[i]); end
      checks++; if (tx_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL full_tx[%0d]: got %02h expected %02h", i, tx_log[i], exp_q[i]); end
    end
    checks++; if (!(acc_cyc[9] > tx_cyc[0])) begin errors++; $display("[TB] FAIL full_ninth_after_pop: got %0d expected >%0d", acc_cyc[9], tx_cyc[0]); end
  endtask

  task automatic test_timeout();
    bit ok;
    int d;
    int budget;
    clear_logs();
    mode = M_SILENT;
    q0.push_back(8'h77); q0.push_back(8'h78);
    wait_tx(1, ok);
    d = tx_cyc[0];
    budget = 50;
    while (err !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    checks++; if (cyc !== d + ACK) begin errors++; $display("[TB] FAIL timeout_err_cycle: got %0d expected %0d", cyc - d, ACK); end
    wait_tx(2, ok);
    checks++; if (tx_log[1] !== 8'h78) begin errors++; $display("[TB] FAIL timeout_next_byte: got %02h expected 78", tx_log[1]); end
    checks++; if (tx_cyc[1] !== d + ACK + GAP + 1) begin errors++; $display("[TB] FAIL timeout_next_launch: got %0d expected %0d", tx_cyc[1] - d, ACK + GAP + 1); end
    wait_idle(ok);
    checks++; if (fifo_count !== 4'd0 || err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_dropped: got count=%0d err=%0h expected 0 and 1", fifo_count, err); end
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %0h expected 0", err); end
    err_clr = 1'b1;
    q0.push_back(8'h79);
    wait_tx(3, ok);
    d = tx_cyc[2];
    while (cyc < d + ACK) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_set_wins: got %0h expected 1", err); end
    err_clr = 1'b0;
    wait_idle(ok);
    checks++; if (tx_log.size() !== 3) begin errors++; $display("[TB] FAIL timeout_no_retry: got %0d expected 3", tx_log.size()); end
    mode = M_NORMAL;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_logs();
    mode = M_HOLD;
    repeat (2) @(negedge clk);
    q0.push_back(8'h51); q0.push_back(8'h52); q0.push_back(8'h53);
    repeat (6) @(negedge clk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("[TB] FAIL midreset_queued: got %0d expected 3", fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", fifo_count); end
    checks++; if ({tx_dv, busy, err} !== 3'b000 || tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL midreset_outputs: got dv/busy/err=%03b byte=%02h expected 000 00", {tx_dv, busy, err}, tx_byte); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    q0.push_back(8'h54);
    repeat (8) @(negedge clk);
    checks++; if (tx_log.size() !== 0 || fifo_count !== 4'd1) begin errors++; $display("[TB] FAIL midreset_hold_off: got frames=%0d count=%0d expected 0 and 1", tx_log.size(), fifo_count); end
    mode = M_NORMAL;
    wait_tx(1, ok);
    checks++; if (tx_log[0] !== 8'h54) begin errors++; $display("[TB] FAIL midreset_byte: got %02h expected 54", tx_log[0]); end
    checks++; if (tx_cyc[0] !== done_log[0] + 2) begin errors++; $display("[TB] FAIL midreset_launch: got %0d expected %0d", tx_cyc[0], done_log[0] + 2); end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    logic [7:0] exp_q[$];
    clear_logs();
    mode = M_HOLD;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
    q0.push_back(8'h60); q0.push_back(8'h61); q0.push_back(8'h62);
    repeat (6) @(negedge clk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("[TB] FAIL b2b_start_count: got %0d expected 3", fifo_count); end
    k = cyc;
    mode = M_NORMAL;
    @(negedge clk) q0.push_back(8'h63);
    repeat (2) @(negedge clk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("[TB] FAIL b2b_count_same: got %0d expected 3", fifo_count); end
    checks++; if (acc_cyc[acc_cyc.size()-1] !== k + 2 || tx_cyc[0] !== k + 3) begin errors++; $display("[TB] FAIL b2b_same_cycle: got push=%0d launch=%0d expected %0d %0d", acc_cyc[acc_cyc.size()-1] - k, tx_cyc[0] - k, 2, 3); end
    for (int i = 0; i < 20; i++) begin
      q0.push_back(8'h80 + 8'(i)); exp_q.push_back(8'h80 + 8'(i));
    end
    wait_tx(24, ok);
    wait_idle(ok);
    checks++; if (tx_log.size() !== 24) begin errors++; $display("[TB] FAIL b2b_frames: got %0d expected 24", tx_log.size()); end
    for (int i = 0; i < 24; i++) begin
      checks++; if (tx_log[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_wrap[%0d]: got %02h expected %02h", i, tx_log[i], exp_q[i]); end
    end
    checks++; if (dv_double !== 0) begin errors++; $display("[TB] FAIL dv_width: got %0d wide pulses expected 0", dv_double); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting uart_tx_sched bench");
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
